// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive buffer:
//   - UART_DATA_WIDTH : character width carried through the buffer (9 bits)
//   - ENTRY_WIDTH     : stored entry width {data, parity error, break}
//   - ENTRY_*         : bit positions of each field inside a stored entry
//   - captureState_t  : state encoding of the receiver capture FSM
//   - packEntry       : builds a stored entry from the receiver status lines
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_WIDTH  = 9;
    localparam int ENTRY_WIDTH      = UART_DATA_WIDTH + 2;
    localparam int ENTRY_BREAK_BIT  = 0;
    localparam int ENTRY_PARITY_BIT = 1;
    localparam int ENTRY_DATA_LSB   = 2;
    localparam int ENTRY_DATA_MSB   = ENTRY_DATA_LSB + UART_DATA_WIDTH - 1;

    typedef enum logic [1:0] {
        CAP_IDLE       = 2'd0,
        CAP_ACK        = 2'd1,
        CAP_WAIT_CLEAR = 2'd2
    } captureState_t;

    // A break reported without a character carries no data and no parity
    // information, so both are forced to zero in that case.
    function automatic logic [ENTRY_WIDTH-1:0] packEntry(
        input logic [UART_DATA_WIDTH-1:0] data,
        input logic                       parityError,
        input logic                       breakSeen,
        input logic                       dataValid
    );
        logic [UART_DATA_WIDTH-1:0] storedData;
        storedData = dataValid ? data : '0;
        return {storedData, parityError & dataValid, breakSeen};
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_fifo_mem
// Register-array storage for the receive FIFO. One synchronous write port,
// one asynchronous read port. Array contents are not reset; validity of the
// head entry is tracked by the surrounding FIFO control.
// Ports:
//   clk        : system clock
//   i_wrEn     : write strobe
//   i_wrAddr   : write address
//   i_wrData   : write data
//   i_rdAddr   : read address
//   o_rdData   : combinational read data at i_rdAddr
// ---------------------------------------------------------------------------
module uart_fifo_mem #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 11
) (
    input  logic                  clk,
    input  logic                  i_wrEn,
    input  logic [DEPTH_LOG2-1:0] i_wrAddr,
    input  logic [WIDTH-1:0]      i_wrData,
    input  logic [DEPTH_LOG2-1:0] i_rdAddr,
    output logic [WIDTH-1:0]      o_rdData
);

    logic [WIDTH-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

    // Plain write port; no reset so this maps onto distributed RAM or flops.
    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side buffer behind the UART receiver. Captures each pending
// character (or break) from the receiver's level-held status, acknowledges
// it with a one-cycle pulse, and stores it with its error flags in a
// first-word-fall-through FIFO read by the host.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   rxData             : character from receiver
//   rxDataReceived     : receiver has a character pending
//   rxParityError      : parity error of pending character
//   rxOverflow         : receiver overwrote an unacknowledged character
//   rxBreak            : receiver detected break
//   rxAck              : one-cycle acknowledge back to the receiver
//   outData            : head entry data (0 when empty)
//   outParityError     : head entry parity flag
//   outBreak           : head entry break flag
//   outValid           : FIFO not empty
//   outReady           : host pops head when outValid && outReady
//   flush              : synchronous empty of the FIFO
//   level              : entries stored, 0..2^DEPTH_LOG2
//   full               : level equals depth
//   lostData           : sticky, an overflow was reported at a capture
//   clearLost          : synchronous clear of lostData
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [uart_pkg::UART_DATA_WIDTH-1:0] rxData,
    input  logic                                 rxDataReceived,
    input  logic                                 rxParityError,
    input  logic                                 rxOverflow,
    input  logic                                 rxBreak,
    output logic                                 rxAck,
    output logic [uart_pkg::UART_DATA_WIDTH-1:0] outData,
    output logic                                 outParityError,
    output logic                                 outBreak,
    output logic                                 outValid,
    input  logic                                 outReady,
    input  logic                                 flush,
    output logic [DEPTH_LOG2:0]                  level,
    output logic                                 full,
    output logic                                 lostData,
    input  logic                                 clearLost
);

    import uart_pkg::*;

    localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    captureState_t            r_state;
    logic                     r_rxAck;
    logic [DEPTH_LOG2-1:0]    r_wrPtr;
    logic [DEPTH_LOG2-1:0]    r_rdPtr;
    logic [DEPTH_LOG2:0]      r_level;
    logic                     r_lostData;

    logic                     w_full;
    logic                     w_outValid;
    logic                     w_capture;
    logic                     w_pop;
    logic [ENTRY_WIDTH-1:0]   w_entryIn;
    logic [ENTRY_WIDTH-1:0]   w_headEntry;

    assign w_full     = (r_level == LEVEL_FULL);
    assign w_outValid = (r_level != '0);

    // Fullness is judged on the level before any same-cycle pop, so a push
    // racing a pop on a full FIFO simply retries on the following cycle.
    assign w_capture  = (r_state == CAP_IDLE) && (rxDataReceived || rxBreak)
                        && !w_full && !flush;
    assign w_pop      = w_outValid && outReady && !flush;
    assign w_entryIn  = packEntry(rxData, rxParityError, rxBreak, rxDataReceived);

    // Capture FSM: take the character, pulse the acknowledge, then wait for
    // the receiver to drop its status so a held character is not taken twice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CAP_IDLE;
            r_rxAck <= 1'b0;
        end else begin
            r_rxAck <= 1'b0;
            case (r_state)
                CAP_IDLE: begin
                    if (w_capture) begin
                        r_state <= CAP_ACK;
                        r_rxAck <= 1'b1;
                    end
                end
                CAP_ACK: begin
                    r_state <= CAP_WAIT_CLEAR;
                end
                CAP_WAIT_CLEAR: begin
                    if (!rxDataReceived && !rxBreak) begin
                        r_state <= CAP_IDLE;
                    end
                end
                default: begin
                    r_state <= CAP_IDLE;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy. Flush wins over everything; capture is
    // already held off during flush so no write can be lost mid-flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_capture) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            case ({w_capture, w_pop})
                2'b10:   r_level <= r_level + LEVEL_ONE;
                2'b01:   r_level <= r_level - LEVEL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky lost-data flag; a new overflow capture beats a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lostData <= 1'b0;
        end else if (w_capture && rxOverflow) begin
            r_lostData <= 1'b1;
        end else if (clearLost) begin
            r_lostData <= 1'b0;
        end
    end

    uart_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (ENTRY_WIDTH)
    ) u_mem (
        .clk      (clk),
        .i_wrEn   (w_capture),
        .i_wrAddr (r_wrPtr),
        .i_wrData (w_entryIn),
        .i_rdAddr (r_rdPtr),
        .o_rdData (w_headEntry)
    );

    // Head fields are masked while empty so stale array contents never show.
    assign outData        = w_outValid ? w_headEntry[ENTRY_DATA_MSB:ENTRY_DATA_LSB] : '0;
    assign outParityError = w_outValid & w_headEntry[ENTRY_PARITY_BIT];
    assign outBreak       = w_outValid & w_headEntry[ENTRY_BREAK_BIT];
    assign outValid       = w_outValid;
    assign rxAck          = r_rxAck;
    assign level          = r_level;
    assign full           = w_full;
    assign lostData       = r_lostData;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer sitting directly downstream of the UART receiver. Drains each completed character (or break event) from the receiver's level-held status outputs and acknowledges it, then stores it with its per-character error flags. Presents entries to the host/register interface as a first-word-fall-through valid/ready stream. Decouples slow host polling from line rate and records characters lost upstream.

## Interface
- DEPTH_LOG2, 4, FIFO depth = 2^DEPTH_LOG2 entries (16)
- clk  input  1  system clock, all logic on posedge
- rst  input  1  asynchronous, active-high reset
- rxData  input  9  character from receiver (bits above configured width are don't-care, stored as given)
- rxDataReceived  input  1  receiver holds high while a character is pending
- rxParityError  input  1  parity error for pending character
- rxOverflow  input  1  receiver overwrote an unacknowledged character
- rxBreak  input  1  receiver detected break (may be high without rxDataReceived)
- rxAck  output  1  one-cycle pulse; drives receiver's receiveData
- outData  output  9  head entry data
- outParityError  output  1  head entry parity flag
- outBreak  output  1  head entry break flag
- outValid  output  1  FIFO not empty
- outReady  input  1  pop head when outValid && outReady
- flush  input  1  synchronous empty of FIFO
- level  output  DEPTH_LOG2+1  entries stored, 0..2^DEPTH_LOG2
- full  output  1  level == depth
- lostData  output  1  sticky: receiver reported rxOverflow at a capture
- clearLost  input  1  synchronous clear of lostData

## Operation
- Capture FSM, states IDLE, ACK, WAIT_CLEAR.
- IDLE: if (rxDataReceived || rxBreak) && !full && !flush -> write entry {rxData, rxParityError && rxDataReceived, rxBreak}; break-only entry stores data 0; go ACK. If full, stay IDLE, no ack (receiver keeps character; further characters overflow upstream).
- ACK: rxAck = 1 for exactly this cycle; go WAIT_CLEAR.
- WAIT_CLEAR: stay until rxDataReceived == 0 && rxBreak == 0, then IDLE. Prevents double capture of a held character.
- rxOverflow sampled at capture; if 1, lostData <= 1. clearLost clears it; set wins over simultaneous clear.
- Read: pop on outValid && outReady; rdPtr advances.
- Pointers DEPTH_LOG2 bits, wrap modulo depth; level = writes − pops, never exceeds depth or drops below 0.
- Simultaneous push and pop: level unchanged; allowed when full (push blocked since full judged on pre-pop level — push retried next cycle) and when level == 1.
- flush: pointers and level to 0, in-flight capture deferred (FSM stays IDLE); lostData unaffected; pop ignored.

## Timing
- Reset values: rxAck 0, outValid 0, outData 0, outParityError 0, outBreak 0, level 0, full 0, lostData 0, FSM IDLE.
- Reset mid-operation: everything above applies immediately (asynchronous); stored entries discarded.
- Capture: condition true in cycle N -> entry written at edge N+1; rxAck high in cycle N+1; level/outValid updated in cycle N+1.
- Write-to-read latency: 1 cycle; outData combinational from head (FWFT), valid same cycle as outValid.
- Pop in cycle N -> next entry on outData in cycle N+1.
- Minimum capture spacing 3 cycles (IDLE, ACK, WAIT_CLEAR).

## Structure
- Shared package uart_pkg: UART_DATA_WIDTH = 9, entry width 11, entry field bit indices, capture FSM state encoding.
- One sub-module: uart_fifo_mem — register-array storage, one write port, one asynchronous read port, no reset on array contents.

## Test plan
- Receiver presents rxData 9'h0A5, rxDataReceived held until ack -> exactly one rxAck pulse, one entry; outData 0A5, outParityError 0, level 1.
- rxDataReceived with rxParityError 1, then rxBreak alone -> two entries: {data, parity 1, break 0} then {000, 0, 1}.
- 17 characters with outReady 0 (DEPTH_LOG2 4) -> 16 acked, full 1, 17th unacked until one pop, then captured next IDLE cycle.
- Capture with rxOverflow 1 -> lostData 1; clearLost pulse -> 0; clearLost coincident with new overflow capture -> stays 1.
- Level 16, push attempt and pop same cycle -> pop only, level 15; push lands next cycle, level 16; pointer wrap preserves order.
- flush with level 5 and concurrent capture -> level 0, outValid 0, capture completes afterwards; async rst during ACK -> rxAck drops immediately.
